// File: rtl/pwm_motor_driver.sv
// Dual-wheel H-bridge driver: shared PWM duty taps plus per-wheel direction FSM
// that inserts a dead time of DEAD_CYCLES clocks on every direction reversal.
module pwm_motor_driver #(
  parameter int unsigned CLK_DIV     = 195,
  parameter int unsigned DEAD_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Drive_En,
  input  logic       Speed_Wheel_1,
  input  logic       Speed_Wheel_2,
  input  logic [1:0] Control_Wheel_1,
  input  logic [1:0] Control_Wheel_2,
  output logic       pwm_255,
  output logic       pwm_250,
  output logic       pwm_220,
  output logic       pwm_150,
  output logic       pwm_0,
  output logic [1:0] Motor_In_1,
  output logic [1:0] Motor_In_2,
  output logic       Motor_En_1,
  output logic       Motor_En_2,
  output logic       Dead_Active_1,
  output logic       Dead_Active_2
);

  localparam logic [15:0] DivLast  = 16'(CLK_DIV - 1);
  localparam logic [15:0] DeadLoad = 16'(DEAD_CYCLES - 1);

  localparam logic [1:0] StStop = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDead = 2'd2;

  logic [15:0] presc_q;
  logic [7:0]  phase_q;
  logic        tick;
  logic [4:0]  taps_q;

  assign tick = (presc_q == DivLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      phase_q <= '0;
    end else if (!Drive_En) begin
      presc_q <= '0;
      phase_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
      phase_q <= phase_q + 8'd1;
    end else begin
      presc_q <= presc_q + 16'd1;
    end
  end

  // Taps compare the current phase, so they lag a phase change by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps_q <= '0;
    end else if (!Drive_En) begin
      taps_q <= '0;
    end else begin
      taps_q <= {phase_q < 8'd255, phase_q < 8'd250, phase_q < 8'd220, phase_q < 8'd150, 1'b0};
    end
  end

  assign {pwm_255, pwm_250, pwm_220, pwm_150, pwm_0} = taps_q;

  logic [1:0]  req        [2];
  logic        spd        [2];
  logic [1:0]  state_q    [2];
  logic [1:0]  state_d    [2];
  logic [1:0]  applied_q  [2];
  logic [1:0]  applied_d  [2];
  logic [15:0] cnt_q      [2];
  logic [15:0] cnt_d      [2];
  logic [1:0]  motor_in_q [2];
  logic        motor_en_q [2];
  logic        dead_q     [2];

  assign req[0] = Control_Wheel_1;
  assign req[1] = Control_Wheel_2;
  assign spd[0] = Speed_Wheel_1;
  assign spd[1] = Speed_Wheel_2;

  // A request is a drive code (01/10) exactly when its two bits differ.
  always_comb begin
    for (int w = 0; w < 2; w++) begin
      state_d[w]   = state_q[w];
      applied_d[w] = applied_q[w];
      cnt_d[w]     = cnt_q[w];
      if (!Drive_En) begin
        state_d[w]   = StStop;
        applied_d[w] = 2'b00;
        cnt_d[w]     = '0;
      end else begin
        case (state_q[w])
          StRun: begin
            if (req[w] != applied_q[w]) begin
              if (req[w][0] ^ req[w][1]) begin
                state_d[w] = StDead;
                cnt_d[w]   = DeadLoad;
              end else begin
                state_d[w] = StStop;
              end
            end
          end
          StDead: begin
            if (cnt_q[w] == '0) begin
              if (req[w][0] ^ req[w][1]) begin
                state_d[w]   = StRun;
                applied_d[w] = req[w];
              end else begin
                state_d[w] = StStop;
              end
            end else begin
              cnt_d[w] = cnt_q[w] - 16'd1;
            end
          end
          default: begin
            if (req[w][0] ^ req[w][1]) begin
              state_d[w]   = StRun;
              applied_d[w] = req[w];
            end
          end
        endcase
      end
    end
  end

  // Outputs are registered from the next state so they change one clock after the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < 2; w++) begin
        state_q[w]    <= StStop;
        applied_q[w]  <= 2'b00;
        cnt_q[w]      <= '0;
        motor_in_q[w] <= 2'b00;
        motor_en_q[w] <= 1'b0;
        dead_q[w]     <= 1'b0;
      end
    end else begin
      for (int w = 0; w < 2; w++) begin
        state_q[w]    <= state_d[w];
        applied_q[w]  <= applied_d[w];
        cnt_q[w]      <= cnt_d[w];
        motor_in_q[w] <= (state_d[w] == StRun) ? applied_d[w] : 2'b00;
        motor_en_q[w] <= (state_d[w] == StRun) & spd[w];
        dead_q[w]     <= (state_d[w] == StDead);
      end
    end
  end

  assign Motor_In_1    = motor_in_q[0];
  assign Motor_In_2    = motor_in_q[1];
  assign Motor_En_1    = motor_en_q[0];
  assign Motor_En_2    = motor_en_q[1];
  assign Dead_Active_1 = dead_q[0];
  assign Dead_Active_2 = dead_q[1];

endmodule

// File: tb/tb_pwm_motor_driver.sv
// Bench for pwm_motor_driver: wheel outputs checked through a scoreboard fed by a
// cycle model; duty, tick timing, dead length and async reset checked directly.
module tb_pwm_motor_driver;

  localparam int unsigned ClkDiv     = 2;
  localparam int unsigned DeadCycles = 10;
  localparam int MStop = 0;
  localparam int MRun  = 1;
  localparam int MDead = 2;

  logic       clk;
  logic       rst_n;
  logic       Drive_En;
  logic       Speed_Wheel_1, Speed_Wheel_2;
  logic [1:0] Control_Wheel_1, Control_Wheel_2;
  logic       pwm_255, pwm_250, pwm_220, pwm_150, pwm_0;
  logic [1:0] Motor_In_1, Motor_In_2;
  logic       Motor_En_1, Motor_En_2, Dead_Active_1, Dead_Active_2;

  pwm_motor_driver #(
    .CLK_DIV    (ClkDiv),
    .DEAD_CYCLES(DeadCycles)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Drive_En       (Drive_En),
    .Speed_Wheel_1  (Speed_Wheel_1),
    .Speed_Wheel_2  (Speed_Wheel_2),
    .Control_Wheel_1(Control_Wheel_1),
    .Control_Wheel_2(Control_Wheel_2),
    .pwm_255        (pwm_255),
    .pwm_250        (pwm_250),
    .pwm_220        (pwm_220),
    .pwm_150        (pwm_150),
    .pwm_0          (pwm_0),
    .Motor_In_1     (Motor_In_1),
    .Motor_In_2     (Motor_In_2),
    .Motor_En_1     (Motor_En_1),
    .Motor_En_2     (Motor_En_2),
    .Dead_Active_1  (Dead_Active_1),
    .Dead_Active_2  (Dead_Active_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] in1;
    logic [1:0] in2;
    logic       en1;
    logic       en2;
    logic       dead1;
    logic       dead2;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         n_tests;
  int         n_fail;
  int         m_st   [2];
  logic [1:0] m_dir  [2];
  int         m_done [2];
  logic [1:0] prev1, prev2;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Wheel model: m_done counts dead clocks already spent, leaving after DeadCycles.
  task automatic model_step(input int w, input logic en, input logic [1:0] req, input logic spd,
                            output logic [1:0] o_in, output logic o_en, output logic o_dead);
    logic drv;
    drv = (req == 2'b01) || (req == 2'b10);
    if (!en) begin
      m_st[w]  = MStop;
      m_dir[w] = 2'b00;
    end else begin
      case (m_st[w])
        MStop: if (drv) begin m_st[w] = MRun; m_dir[w] = req; end
        MRun: begin
          if (req != m_dir[w]) begin
            if (drv) begin m_st[w] = MDead; m_done[w] = 1; end
            else m_st[w] = MStop;
          end
        end
        default: begin
          if (m_done[w] == int'(DeadCycles)) begin
            if (drv) begin m_st[w] = MRun; m_dir[w] = req; end
            else m_st[w] = MStop;
          end else begin
            m_done[w]++;
          end
        end
      endcase
    end
    o_in   = (m_st[w] == MRun) ? m_dir[w] : 2'b00;
    o_en   = (m_st[w] == MRun) && spd;
    o_dead = (m_st[w] == MDead);
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_st[w]   = MStop;
      m_dir[w]  = 2'b00;
      m_done[w] = 0;
    end
  endtask

  // Called at a negedge: drive inputs, queue the expected post-edge outputs, wait one clock.
  task automatic drive_cycle(input logic en, input logic [1:0] r1, input logic [1:0] r2,
                             input logic s1, input logic s2);
    exp_t x;
    Drive_En        = en;
    Control_Wheel_1 = r1;
    Control_Wheel_2 = r2;
    Speed_Wheel_1   = s1;
    Speed_Wheel_2   = s2;
    model_step(0, en, r1, s1, x.in1, x.en1, x.dead1);
    model_step(1, en, r2, s2, x.in2, x.en2, x.dead2);
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_val(tag, {30'd0, Motor_In_1}, 32'd0);
    check_val(tag, {28'd0, Motor_In_2, Motor_En_1, Motor_En_2}, 32'd0);
    check_val(tag, {30'd0, Dead_Active_1, Dead_Active_2}, 32'd0);
    check_val(tag, {27'd0, pwm_255, pwm_250, pwm_220, pwm_150, pwm_0}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // pwm_150 must stay high through edge 300 and fall at edge 301 when the first
  // tick lands CLK_DIV clocks after reset release.
  task automatic tick_timing(input string tag);
    for (int k = 1; k <= 301; k++) begin
      drive_cycle(1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
      if (k == 1) check_val({tag, "_first"}, {30'd0, pwm_255, pwm_0}, 32'd2);
      if (k == 300) check_val({tag, "_300"}, {31'd0, pwm_150}, 32'd1);
      if (k == 301) check_val({tag, "_301"}, {31'd0, pwm_150}, 32'd0);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("motor_in_1", {30'd0, Motor_In_1}, {30'd0, e.in1});
      check_val("motor_in_2", {30'd0, Motor_In_2}, {30'd0, e.in2});
      check_val("motor_en", {30'd0, Motor_En_1, Motor_En_2}, {30'd0, e.en1, e.en2});
      check_val("dead_active", {30'd0, Dead_Active_1, Dead_Active_2}, {30'd0, e.dead1, e.dead2});
    end
    if (rst_n) begin
      check_val("no_rev_1", {31'd0, (Motor_In_1 == 2'b11) ||
                (prev1 != 2'b00 && Motor_In_1 != 2'b00 && prev1 != Motor_In_1)}, 32'd0);
      check_val("no_rev_2", {31'd0, (Motor_In_2 == 2'b11) ||
                (prev2 != 2'b00 && Motor_In_2 != 2'b00 && prev2 != Motor_In_2)}, 32'd0);
    end
    prev1 = Motor_In_1;
    prev2 = Motor_In_2;
  end

  initial begin
    int cnt [5];
    int d1, d2;
    n_tests = 0;
    n_fail  = 0;
    prev1 = 2'b00;
    prev2 = 2'b00;
    model_reset();
    rst_n = 1'b1;
    Drive_En = 1'b1;
    Control_Wheel_1 = 2'b00;
    Control_Wheel_2 = 2'b00;
    Speed_Wheel_1 = 1'b0;
    Speed_Wheel_2 = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check_val("reset_motor", {26'd0, Motor_In_1, Motor_In_2, Motor_En_1, Motor_En_2}, 32'd0);
    check_val("reset_dead", {30'd0, Dead_Active_1, Dead_Active_2}, 32'd0);
    check_val("reset_taps", {27'd0, pwm_255, pwm_250, pwm_220, pwm_150, pwm_0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    tick_timing("tick_after_reset");

    // One full 256-phase period spans 512 clocks at CLK_DIV=2.
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    for (int k = 0; k < 512; k++) begin
      drive_cycle(1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
      cnt[0] += int'(pwm_255);
      cnt[1] += int'(pwm_250);
      cnt[2] += int'(pwm_220);
      cnt[3] += int'(pwm_150);
      cnt[4] += int'(pwm_0);
    end
    check_val("duty_255", cnt[0], 32'd510);
    check_val("duty_250", cnt[1], 32'd500);
    check_val("duty_220", cnt[2], 32'd440);
    check_val("duty_150", cnt[3], 32'd300);
    check_val("duty_0", cnt[4], 32'd0);

    for (int k = 0; k < 20; k++) drive_cycle(1'b1, 2'b01, 2'b00, 1'($urandom), 1'($urandom));

    d1 = 0;
    for (int k = 0; k < 15; k++) begin
      drive_cycle(1'b1, 2'b10, 2'b00, 1'($urandom), 1'b0);
      d1 += int'(Dead_Active_1);
    end
    check_val("reverse_dead_len", d1, DeadCycles);
    check_val("reverse_dir", {30'd0, Motor_In_1}, 32'd2);

    for (int k = 0; k < 13; k++) drive_cycle(1'b1, 2'b01, 2'b00, 1'b1, 1'b0);
    d1 = 0;
    for (int k = 0; k < 14; k++) begin
      drive_cycle(1'b1, (k < 3) ? 2'b10 : ((k < 6) ? 2'b01 : 2'b00), 2'b00, 1'b1, 1'b0);
      d1 += int'(Dead_Active_1);
    end
    check_val("change_dead_len", d1, DeadCycles);
    check_val("change_stop", {30'd0, Motor_In_1}, 32'd0);

    for (int k = 0; k < 3; k++) drive_cycle(1'b1, 2'b01, 2'b10, 1'b1, 1'b1);
    d1 = 0;
    d2 = 0;
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b1, 2'b10, 2'b01, 1'b1, 1'b1);
      d1 += int'(Dead_Active_1);
      d2 += int'(Dead_Active_2);
    end
    check_val("simul_dead_1", d1, 32'd4);
    check_val("simul_dead_2", d2, 32'd4);
    drive_cycle(1'b0, 2'b10, 2'b01, 1'b1, 1'b1);
    check_val("abort_taps", {27'd0, pwm_255, pwm_250, pwm_220, pwm_150, pwm_0}, 32'd0);
    drive_cycle(1'b0, 2'b10, 2'b01, 1'b1, 1'b1);
    drive_cycle(1'b1, 2'b10, 2'b01, 1'b1, 1'b0);
    check_val("reenable_taps", {27'd0, pwm_255, pwm_250, pwm_220, pwm_150, pwm_0}, 32'h1e);
    for (int k = 0; k < 4; k++) drive_cycle(1'b1, 2'b10, 2'b01, 1'($urandom), 1'($urandom));

    check_val("pre_rst_run", {30'd0, Motor_In_1}, 32'd2);
    async_reset("rst_mid_run");
    for (int k = 0; k < 2; k++) drive_cycle(1'b1, 2'b01, 2'b10, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) drive_cycle(1'b1, 2'b10, 2'b01, 1'b1, 1'b1);
    check_val("pre_rst_dead", {30'd0, Dead_Active_1, Dead_Active_2}, 32'd3);
    async_reset("rst_mid_dead");
    tick_timing("tick_after_rst_dead");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
